unidade_busca: RTL
==================

UNIDADE_BUSCA -- requirements
Module: unidade_busca

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, the prefetch queue entries (legal 2..8).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_req_valid  output  1  a fetch request is presented.
REQ-006 SHALL have port mem_req_addr  output  32  the fetch byte address, word aligned.
REQ-007 SHALL have port mem_req_ready  input  1  the memory accepts the request this cycle.
REQ-008 SHALL have port mem_resp_valid  input  1  the instruction word is returned this cycle.
REQ-009 SHALL have port mem_resp_data  input  32  the returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  the datapath takes a branch this cycle.
REQ-011 SHALL have port redirect_pc  input  32  the branch target.
REQ-012 SHALL have port instr_valid  output  1  an instruction is offered to the datapath.
REQ-013 SHALL have port instr_data  output  32  the offered instruction.
REQ-014 SHALL have port instr_pc  output  32  the address of instr_data.
REQ-015 SHALL have port instr_ready  input  1  the datapath consumes the offered instruction.

Function
REQ-016 SHALL hold fetch_pc; a request fires on mem_req_valid&mem_req_ready, and fetch_pc then advances by 4, wrapping 32'hFFFF_FFFC to 0.
REQ-017 SHALL drive mem_req_addr = fetch_pc, held stable while mem_req_valid=1 and mem_req_ready=0.
REQ-018 SHALL assert mem_req_valid only in state FETCH with (queue count + outstanding) < FIFO_DEPTH and redirect_valid=0.
REQ-019 SHALL treat memory responses as in-order, at least one cycle after acceptance; outstanding counts 0..FIFO_DEPTH.
REQ-020 SHALL push {pc, mem_resp_data} into the queue on a non-discarded response; instr_valid rises the following cycle (1-cycle registered latency).
REQ-021 SHALL drive instr_valid = queue non-empty & !redirect_valid; a transfer occurs on instr_valid&instr_ready.
REQ-022 SHALL drive instr_data = 32'h0000_0013 (NOP) and instr_pc = 0 whenever instr_valid=0.
REQ-023 SHALL support a push and a pop in the same cycle, including when the queue is full, with the count unchanged.
REQ-024 SHALL implement FSM states FETCH and DRAIN, and reset to FETCH.
REQ-025 SHALL, on redirect_valid, clear the queue, load fetch_pc = {redirect_pc[31:2], 2'b00}, set discard = outstanding (excluding any response arriving that same cycle, which is dropped), and go to DRAIN if discard > 0, else stay in FETCH.
REQ-026 SHALL, in DRAIN, drop each response and decrement discard, and go to FETCH in the cycle discard reaches 0; no request is issued in DRAIN.
REQ-027 SHALL, on a redirect while in DRAIN, reload fetch_pc and keep the current discard count.
REQ-028 SHALL give redirect priority over a simultaneous pop, push, or request.

Reset
REQ-029 SHALL, while reset=1, force mem_req_valid=0, instr_valid=0, queue empty, outstanding=0, discard=0, state FETCH, and fetch_pc=RESET_PC.
REQ-030 SHALL ignore responses to requests issued before reset; the memory is reset in the same cycle.
REQ-031 SHALL present its first request, at RESET_PC, in the first cycle after reset deasserts.

Structure
REQ-032 SHALL take the NOP encoding, the FSM state encoding and the RESET_PC default from shared package riscv_pkg.
REQ-033 SHALL instantiate one sub-module, fila_instrucao, a synchronous FIFO of {pc[31:0], instr[31:0]} with push, pop, count, full and empty.

Verification
REQ-034 SHALL cover: memory always ready with 1-cycle response, instr_ready=1 -> instr_pc sequence 0, 4, 8, 12, with instr_valid continuous from cycle 3.
REQ-035 SHALL cover: instr_ready=0 for 10 cycles -> exactly 2 requests (0x0, 0x4) issued, then mem_req_valid=0 until the first pop.
REQ-036 SHALL cover: redirect_pc=0x100 with 2 outstanding requests -> both responses dropped, DRAIN for 2 responses, next request address 0x100, first instr_pc=0x100.
REQ-037 SHALL cover: redirect_pc=0x203 with 0 outstanding -> next-cycle request at 0x200, state stays FETCH.
REQ-038 SHALL cover: fetch_pc=0xFFFF_FFFC accepted -> next request address 0x0000_0000.
REQ-039 SHALL cover: reset asserted with 1 outstanding request and a full queue -> next cycle instr_valid=0 and mem_req_addr=RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: NOP encoding, fetch FSM encoding, reset vector
// and the queue entry layout.
package riscv_pkg;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fila_instrucao.sv
// Synchronous prefetch FIFO of {pc, instr}; accepts push and pop together even when full.
module fila_instrucao
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                push,
  input  fetch_entry_t        push_data,
  input  logic                pop,
  output fetch_entry_t        pop_data,
  output logic [CW-1:0]       count,
  output logic                full,
  output logic                empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic           push_ok, pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: issues sequential word fetches, queues in-order responses,
// and on a branch flushes the queue and drains stale responses before refetching.
module unidade_busca
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [0:0]    state;
  logic [31:0]   fetch_pc, resp_pc, redir_aligned;
  logic [CW-1:0] outstanding, discard, q_count, stale;
  logic          q_full, q_empty, push, pop, fire;
  logic [CW:0]   inflight;
  fetch_entry_t  q_head, q_in;

  assign redir_aligned = redirect_pc & ~32'h3;
  assign fire          = mem_req_valid & mem_req_ready;
  assign pop           = instr_valid & instr_ready;
  assign push          = ~reset & mem_resp_valid & (state == ST_FETCH) & ~redirect_valid;
  assign q_in          = '{pc: resp_pc, instr: mem_resp_data};
  // Slot freed by a same-cycle pop counts as credit, so a 2-deep queue can stream
  // one instruction per cycle against a 1-cycle memory.
  assign inflight = {1'b0, q_count} + {1'b0, outstanding} - {{CW{1'b0}}, pop};
  assign stale    = outstanding - CW'(mem_resp_valid);

  assign mem_req_valid = ~reset & (state == ST_FETCH) & ~redirect_valid &
                         (~q_full | pop) & (inflight < (CW + 1)'(FIFO_DEPTH));
  assign mem_req_addr  = fetch_pc;

  assign instr_valid = ~reset & ~q_empty & ~redirect_valid;
  assign instr_data  = instr_valid ? q_head.instr : NOP_INSTR;
  assign instr_pc    = instr_valid ? q_head.pc    : 32'h0;

  fila_instrucao #(.DEPTH(FIFO_DEPTH)) u_fila (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (push),
    .push_data(q_in),
    .pop      (pop),
    .pop_data (q_head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_FETCH;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(fire) - CW'(mem_resp_valid);
      if (redirect_valid) begin
        fetch_pc <= redir_aligned;
        resp_pc  <= redir_aligned;
        if (state == ST_FETCH) begin
          // A response landing with the redirect is dropped, so it is not owed.
          discard <= stale;
          state   <= (stale != '0) ? ST_DRAIN : ST_FETCH;
        end
      end else begin
        if (fire) fetch_pc <= fetch_pc + 32'd4;
        if (push) resp_pc  <= resp_pc + 32'd4;
      end
      if (state == ST_DRAIN && mem_resp_valid) begin
        discard <= discard - 1'b1;
        if (discard == CW'(1)) state <= ST_FETCH;
      end
    end
  end
endmodule
